// File: rtl/lab1_2_bist.sv
// Self-test initiator for the signed 4-bit adder/subtractor lab1_2: sweeps all 512 {m,a,b} vectors.
// Optional macro LAB1_2_BIST_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module lab1_2_bist #(
  parameter int SETTLE_CYC = 1,
  parameter int ERR_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [3:0]       a_out,
  output logic [3:0]       b_out,
  output logic             m_out,
  input  logic [3:0]       s_in,
  input  logic             v_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [8:0]       first_fail,
  output logic             fail_seen
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  state_t     state, state_nxt;
  logic [8:0] idx;
  logic [8:0] vec;
  logic [3:0] cnt;
  logic [3:0] s_exp;
  logic       v_exp;
  logic       mismatch;
  logic       last_vec;

  assign {m_out, a_out, b_out} = vec;
  assign busy = (state == DRIVE) || (state == WAIT) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_cnt == '0);
  assign last_vec = (idx == 9'h1FF);

  // Expected result is taken from the held vector, not idx, so it matches what lab1_2 actually sees.
  always_comb begin
    s_exp    = a_out + (m_out ? (~b_out + 4'd1) : b_out);
    v_exp    = m_out ? ((a_out[3] != b_out[3]) && (s_exp[3] != a_out[3]))
                     : ((a_out[3] == b_out[3]) && (s_exp[3] != a_out[3]));
    mismatch = (s_in != s_exp) || (v_in != v_exp);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = DRIVE;
      DRIVE: state_nxt = WAIT;
      WAIT:  if (cnt <= 4'd1) state_nxt = CHECK;
      CHECK: begin
`ifdef LAB1_2_BIST_STOP_ON_FAIL_EN
        if (last_vec || mismatch) state_nxt = DONE;
`else
        if (last_vec) state_nxt = DONE;
`endif
        else state_nxt = DRIVE;
      end
      DONE:  if (start) state_nxt = DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      vec        <= '0;
      cnt        <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx        <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
          end
        end
        DRIVE: begin
          vec <= idx;
          cnt <= 4'(SETTLE_CYC);
        end
        WAIT: cnt <= cnt - 4'd1;
        CHECK: begin
          if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (!fail_seen) begin
              first_fail <= vec;
              fail_seen  <= 1'b1;
            end
          end
          if (!last_vec) idx <= idx + 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lab1_2_bist.sv
// Bench for lab1_2_bist: emulates lab1_2 (optionally faulty) and checks each sweep against an integer-arithmetic reference.
module tb_lab1_2_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a_out, b_out, s_in;
  logic       m_out, v_in;
  logic       busy, done, pass, fail_seen;
  logic [9:0] err_cnt;
  logic [8:0] first_fail;

  int checks = 0;
  int errors = 0;

  // 0: correct adder, 1: s[0] stuck 0, 2: v stuck 0, 3: random corruption table
  int         fault_mode = 0;
  logic [3:0] bad_s [512];
  logic       bad_v [512];
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  lab1_2_bist dut (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a_out), .b_out(b_out), .m_out(m_out),
    .s_in(s_in), .v_in(v_in),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_fail(first_fail), .fail_seen(fail_seen)
  );

  // Signed arithmetic on plain integers: overflow means the true result leaves [-8,7].
  function automatic logic [4:0] ref_op(input int idx);
    int m, a, b, r;
    m = (idx >> 8) & 1;
    a = (idx >> 4) & 15;
    b = idx & 15;
    if (a >= 8) a = a - 16;
    if (b >= 8) b = b - 16;
    r = (m != 0) ? a - b : a + b;
    return {(r > 7 || r < -8) ? 1'b1 : 1'b0, 4'(r & 15)};
  endfunction

  function automatic logic [4:0] faulty_op(input int idx);
    logic [4:0] vs;
    vs = ref_op(idx);
    case (fault_mode)
      1: vs[0] = 1'b0;
      2: vs[4] = 1'b0;
      3: vs = vs ^ {bad_v[idx], bad_s[idx]};
      default: ;
    endcase
    return vs;
  endfunction

  always_comb begin
    logic [4:0] vs;
    vs = faulty_op({23'd0, m_out, a_out, b_out});
    s_in = vs[3:0];
    v_in = vs[4];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_faults();
    for (int i = 0; i < 512; i++) begin
      bad_s[i] = 4'd0;
      bad_v[i] = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) bad_s[i] = 4'($urandom_range(1, 15));
        else bad_v[i] = 1'b1;
      end
    end
  endtask

  task automatic run_sweep(input int repulse, output int nbusy, output bit timed_out);
    nbusy = 0;
    timed_out = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nbusy++;
      if (nbusy == repulse) start = 1'b1;
      if (done && !busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic verify_run(input string tag, input int repulse);
    int nbusy, exp_err, exp_first, exp_busy, exp_last;
    bit to;
    exp_q.delete();
    for (int i = 0; i < 512; i++)
      if (faulty_op(i) != ref_op(i)) exp_q.push_back(9'(i));
    exp_err   = exp_q.size();
    exp_first = (exp_err > 0) ? int'(exp_q[0]) : 0;
    exp_busy  = 1536;
    exp_last  = 9'h1FF;
`ifdef LAB1_2_BIST_STOP_ON_FAIL_EN
    if (exp_err > 0) begin
      exp_err  = 1;
      exp_busy = 3 * (exp_first + 1);
      exp_last = exp_first;
    end
`endif
    run_sweep(repulse, nbusy, to);
    check({tag, " timeout"}, 32'(to), 32'd0);
    check({tag, " busy_cycles"}, nbusy, exp_busy);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " pass"}, 32'(pass), (exp_err == 0) ? 32'd1 : 32'd0);
    check({tag, " err_cnt"}, 32'(err_cnt), exp_err);
    check({tag, " first_fail"}, 32'(first_fail), exp_first);
    check({tag, " fail_seen"}, 32'(fail_seen), (exp_err > 0) ? 32'd1 : 32'd0);
    check({tag, " last_vec"}, 32'({m_out, a_out, b_out}), exp_last);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " a_out"}, 32'(a_out), 32'd0);
    check({tag, " b_out"}, 32'(b_out), 32'd0);
    check({tag, " m_out"}, 32'(m_out), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " pass"}, 32'(pass), 32'd0);
    check({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, " first_fail"}, 32'(first_fail), 32'd0);
    check({tag, " fail_seen"}, 32'(fail_seen), 32'd0);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // golden adder, then faults; each restart from DONE must clear results
    fault_mode = 0; verify_run("clean", 0);
    fault_mode = 1; verify_run("s0_stuck", 0);
    fault_mode = 2; verify_run("v_stuck", 0);
    fault_mode = 3; randomize_faults(); verify_run("random1", 0);
    randomize_faults(); verify_run("random2", 0);

    // reset in the middle of a faulty sweep
    fault_mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    check("mid busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_rst");
    rst = 1'b0;
    fault_mode = 0; verify_run("after_rst", 0);

    // start re-pulsed while busy must be ignored
    fault_mode = 2; verify_run("repulse", 50);
    fault_mode = 0; verify_run("rerun", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
